// File: rtl/rx_ap_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : rx_ap_axil_regs
// Description : AXI4-Lite slave register bank of the RX_Block_AP peripheral.
//               Four 32-bit read/write configuration registers at byte
//               offsets 0x0, 0x4, 0x8 and 0xC. They are presented continuously
//               to the RX datapath. A one-cycle write strobe per register
//               marks each completed write.
//
// Optional feature (compile-time macro):
//   RX_AP_ADDR_CHECK_EN - when defined, any address with a nonzero bit above
//                         [3:0] is out of range. A write to such an address
//                         changes nothing, raises no strobe and gets SLVERR.
//                         A read returns zero data with SLVERR. When the macro
//                         is undefined, only bits [3:2] are decoded, so upper
//                         address bits alias.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn  clock, asynchronous active-low reset
//   s00_axi_aw* / w* / b*           AXI4-Lite write address, data, response
//   s00_axi_ar* / r*                AXI4-Lite read address, data
//   cfg_reg0_o .. cfg_reg3_o        current register contents
//   cfg_wr_stb_o                    one-cycle pulse; bit k = register k written
//
// Revision    : 1.0 - initial release
// ============================================================================
module rx_ap_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3_o,
    output logic [3:0]                      cfg_wr_stb_o
);

    localparam int         c_NUM_REGS    = 4;
    localparam int         c_NUM_BYTES   = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------------
    // Registered channel state
    // ------------------------------------------------------------------------
    logic                          r_awready;   // also serves as wready
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [3:0]                    r_wr_stb;

    logic [C_S_AXI_DATA_WIDTH-1:0] w_regs [c_NUM_REGS];

    logic [1:0] w_aw_idx;
    logic [1:0] w_ar_idx;
    logic [3:0] w_aw_sel;
    logic       w_aw_oor;
    logic       w_ar_oor;
    logic       w_wr_start;
    logic       w_wr_en;
    logic       w_rd_start;
    logic       w_rd_en;

    assign w_aw_idx = s00_axi_awaddr[3:2];
    assign w_ar_idx = s00_axi_araddr[3:2];
    assign w_aw_sel = 4'b0001 << w_aw_idx;

    // ------------------------------------------------------------------------
    // Out-of-range address detection
    // ------------------------------------------------------------------------
`ifdef RX_AP_ADDR_CHECK_EN
    generate
        if (C_S_AXI_ADDR_WIDTH > 4) begin : g_addr_chk
            assign w_aw_oor = |s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4];
            assign w_ar_oor = |s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4];
        end else begin : g_addr_nochk
            assign w_aw_oor = 1'b0;
            assign w_ar_oor = 1'b0;
        end
    endgenerate
`else
    assign w_aw_oor = 1'b0;
    assign w_ar_oor = 1'b0;
    generate
        if (C_S_AXI_ADDR_WIDTH > 4) begin : g_addr_alias
            // The upper bits alias onto the four registers and are not decoded.
            logic w_unused_hi;
            assign w_unused_hi = ^{s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4],
                                   s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4]};
        end
    endgenerate
`endif

    // The protection fields and the byte-offset bits carry no meaning here.
    logic w_unused_ok;
    assign w_unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // ------------------------------------------------------------------------
    // Write channel
    // AW and W are accepted only together. The accept pulse lasts one cycle
    // and is suppressed while a response is still outstanding. Because the
    // master must hold its valids until ready, the handshake completes on the
    // edge that ends the ready cycle.
    // ------------------------------------------------------------------------
    assign w_wr_start = s00_axi_awvalid & s00_axi_wvalid & ~r_awready & ~r_bvalid;
    assign w_wr_en    = r_awready & s00_axi_awvalid & s00_axi_wvalid;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_wr_stb  <= 4'b0000;
        end else begin
            r_awready <= w_wr_start;
            r_wr_stb  <= 4'b0000;
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_oor ? c_RESP_SLVERR : c_RESP_OKAY;
                if (!w_aw_oor) begin
                    r_wr_stb <= w_aw_sel;
                end
            end else if (r_bvalid && s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register storage with byte enables
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < c_NUM_REGS; k++) begin : g_reg
            logic [C_S_AXI_DATA_WIDTH-1:0] r_q;

            always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
                if (!s00_axi_aresetn) begin
                    r_q <= '0;
                end else if (w_wr_en && !w_aw_oor && w_aw_sel[k]) begin
                    for (int b = 0; b < c_NUM_BYTES; b++) begin
                        if (s00_axi_wstrb[b]) begin
                            r_q[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                        end
                    end
                end
            end

            assign w_regs[k] = r_q;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read channel
    // Read data is captured from the register outputs on the handshake edge.
    // A write committing on that same edge is therefore not yet visible, and
    // the read returns the value held before the write.
    // ------------------------------------------------------------------------
    assign w_rd_start = s00_axi_arvalid & ~r_arready & ~r_rvalid;
    assign w_rd_en    = r_arready & s00_axi_arvalid;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_arready <= w_rd_start;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                if (w_ar_oor) begin
                    r_rdata <= '0;
                    r_rresp <= c_RESP_SLVERR;
                end else begin
                    r_rdata <= w_regs[w_ar_idx];
                    r_rresp <= c_RESP_OKAY;
                end
            end else if (r_rvalid && s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_awready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rresp   = r_rresp;
    assign s00_axi_rdata   = r_rdata;

    assign cfg_reg0_o   = w_regs[0];
    assign cfg_reg1_o   = w_regs[1];
    assign cfg_reg2_o   = w_regs[2];
    assign cfg_reg3_o   = w_regs[3];
    assign cfg_wr_stb_o = r_wr_stb;

endmodule
`default_nettype wire

// File: tb/tb_rx_ap_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_ap_axil_regs
// Description : Self-checking bench for rx_ap_axil_regs. It is built with a
//               6-bit address so that aliasing and range checks can be
//               exercised. Expectations follow RX_AP_ADDR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_ap_axil_regs;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [31:0]   cfg0, cfg1, cfg2, cfg3;
    logic [3:0]    stb;

    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [31:0]   model [4];

    always #5 clk = ~clk;

    rx_ap_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .cfg_reg0_o      (cfg0),
        .cfg_reg1_o      (cfg1),
        .cfg_reg2_o      (cfg2),
        .cfg_reg3_o      (cfg3),
        .cfg_wr_stb_o    (stb)
    );

    function automatic logic [31:0] cfg_of(input int k);
        case (k)
            0:       return cfg0;
            1:       return cfg1;
            2:       return cfg2;
            default: return cfg3;
        endcase
    endfunction

    // Reference byte-enable merge: keep old bytes where strobe is 0.
    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Bus helper: single write. lat = cycles from presenting to seeing ready
    // (-1 on timeout). stb1 is sampled the cycle after the handshake, and stb2
    // one cycle later.
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int lat, output logic bv, output logic [1:0] resp,
                            output logic [3:0] stb1, output logic [3:0] stb2);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        bv = 1'bx; resp = 2'bxx; stb1 = 4'bxxxx; stb2 = 4'bxxxx;
        @(posedge clk); #1; lat = 1;
        while (!(awready === 1'b1) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (awready !== 1'b1) begin
            lat = -1; awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        bv = bvalid; resp = bresp; stb1 = stb;
        @(posedge clk); #1;
        stb2 = stb;
    endtask

    // Bus helper: single read.
    task automatic do_read(input logic [AW-1:0] a, output int lat, output logic rv,
                           output logic [31:0] d, output logic [1:0] resp);
        araddr = a; arvalid = 1'b1;
        rv = 1'bx; d = 'x; resp = 2'bxx;
        @(posedge clk); #1; lat = 1;
        while (!(arready === 1'b1) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (arready !== 1'b1) begin
            lat = -1; arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        rv = rvalid; d = rdata; resp = rresp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        awaddr = '0; araddr = '0; awprot = 3'b101; arprot = 3'b010;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        wdata = '0; wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) model[k] = '0;
        @(posedge clk); #1;
        tests_run++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: got %b expected 00000", {awready, wready, bvalid, arready, rvalid});
        end
        tests_run++;
        if ({bresp, rresp, rdata, stb} !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_resp_data: got %h/%h/%h/%h expected 0", bresp, rresp, rdata, stb);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (cfg_of(k) !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_cfg%0d: got %h expected 0", k, cfg_of(k));
            end
        end
    endtask

    task automatic test_basic();
        int lat; logic v; logic [1:0] r; logic [3:0] s1, s2; logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            do_write(AW'(k * 4), 32'(k + 1), 4'hF, lat, v, r, s1, s2);
            model[k] = 32'(k + 1);
            tests_run++;
            if (lat !== 1 || v !== 1'b1 || r !== 2'b00 || s1 !== (4'b0001 << k) || s2 !== 4'b0) begin
                tests_failed++;
                $display("FAIL basic_write%0d: got lat=%0d bv=%b resp=%b stb=%b/%b expected 1/1/00/%b/0000",
                         k, lat, v, r, s1, s2, 4'b0001 << k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            do_read(AW'(k * 4), lat, v, d, r);
            tests_run++;
            if (lat !== 1 || v !== 1'b1 || d !== model[k] || r !== 2'b00) begin
                tests_failed++;
                $display("FAIL basic_read%0d: got lat=%0d rv=%b data=%h resp=%b expected 1/1/%h/00",
                         k, lat, v, d, r, model[k]);
            end
            tests_run++;
            if (cfg_of(k) !== model[k]) begin
                tests_failed++;
                $display("FAIL basic_cfg%0d: got %h expected %h", k, cfg_of(k), model[k]);
            end
        end
    endtask

    task automatic test_same_edge();
        int lat; logic v; logic [1:0] r; logic [31:0] d; logic [31:0] old_v;
        old_v = model[2];
        awaddr = 6'h08; wdata = 32'h55; wstrb = 4'hF; araddr = 6'h08;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); #1;
        tests_run++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_edge_ready: got aw=%b ar=%b expected 1 1", awready, arready);
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        model[2] = 32'h55;
        tests_run++;
        if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_edge_old: got rv=%b data=%h bv=%b expected 1 %h 1", rvalid, rdata, bvalid, old_v);
        end
        @(posedge clk); #1;
        do_read(6'h08, lat, v, d, r);
        tests_run++;
        if (d !== model[2] || v !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_edge_new: got %h expected %h", d, model[2]);
        end
    endtask

    task automatic test_strobe();
        int lat; logic v; logic [1:0] r; logic [3:0] s1, s2; logic [31:0] d;
        do_write(6'h04, 32'hAABBCCDD, 4'hF, lat, v, r, s1, s2);
        model[1] = merge(model[1], 32'hAABBCCDD, 4'hF);
        tests_run++;
        if (s1 !== 4'b0010 || s2 !== 4'b0000) begin
            tests_failed++;
            $display("FAIL strobe_pulse1: got %b/%b expected 0010/0000", s1, s2);
        end
        do_write(6'h04, 32'h11223344, 4'b0101, lat, v, r, s1, s2);
        model[1] = merge(model[1], 32'h11223344, 4'b0101);
        tests_run++;
        if (s1 !== 4'b0010 || s2 !== 4'b0000 || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL strobe_pulse2: got %b/%b resp=%b expected 0010/0000/00", s1, s2, r);
        end
        do_read(6'h04, lat, v, d, r);
        tests_run++;
        if (d !== model[1] || d !== 32'hAA22CC44) begin
            tests_failed++;
            $display("FAIL strobe_merge: got %h expected %h", d, model[1]);
        end
    endtask

    task automatic test_wstrb_zero();
        int lat; logic v; logic [1:0] r; logic [3:0] s1, s2;
        do_write(6'h04, $urandom, 4'b0000, lat, v, r, s1, s2);
        tests_run++;
        if (lat !== 1 || v !== 1'b1 || r !== 2'b00 || s1 !== 4'b0010 || cfg1 !== model[1]) begin
            tests_failed++;
            $display("FAIL wstrb_zero: got lat=%0d bv=%b resp=%b stb=%b cfg1=%h expected 1/1/00/0010/%h",
                     lat, v, r, s1, cfg1, model[1]);
        end
    endtask

    task automatic test_aw_before_w();
        int early; int held_bad; int lat; logic [31:0] x, y;
        x = $urandom; y = $urandom;
        bready = 0;
        awaddr = 6'h08; wstrb = 4'hF; awvalid = 1; wvalid = 0;
        early = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (awready !== 1'b0 || wready !== 1'b0) early++;
        end
        tests_run++;
        if (early !== 0) begin
            tests_failed++;
            $display("FAIL aw_alone_ready: got %0d early ready cycles expected 0", early);
        end
        wdata = x; wvalid = 1;
        @(posedge clk); #1;
        tests_run++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            tests_failed++;
            $display("FAIL aw_w_ready: got aw=%b w=%b expected 1 1", awready, wready);
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        model[2] = x;
        // Second write is presented while the first response is unacknowledged.
        awaddr = 6'h0C; wdata = y; awvalid = 1; wvalid = 1;
        held_bad = 0;
        repeat (5) begin
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) held_bad++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (held_bad !== 0 || cfg3 !== model[3]) begin
            tests_failed++;
            $display("FAIL b_hold_stall: got %0d bad cycles cfg3=%h expected 0 %h", held_bad, cfg3, model[3]);
        end
        bready = 1;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (awready !== 1'b1 && lat < 10);
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL stall_release_lat: got %0d expected 2", lat);
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        model[3] = y;
        @(posedge clk); #1;
        tests_run++;
        if (cfg2 !== model[2] || cfg3 !== model[3]) begin
            tests_failed++;
            $display("FAIL aw_before_w_data: got %h %h expected %h %h", cfg2, cfg3, model[2], model[3]);
        end
    endtask

    task automatic test_back_to_back();
        int q[$]; logic [31:0] d;
        d = $urandom;
        awaddr = 6'h0C; wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (awready === 1'b1) begin
                q.push_back(c);
                if (q.size() == 3) break;
            end
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        model[3] = d;
        tests_run++;
        if (q.size() != 3 || q[0] != 1 || q[1] != 4 || q[2] != 7) begin
            tests_failed++;
            $display("FAIL b2b_write: got %0d handshakes %p expected cycles 1,4,7", q.size(), q);
        end
        @(posedge clk); #1;
        q.delete();
        araddr = 6'h0C; arvalid = 1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (arready === 1'b1) begin
                q.push_back(c);
                if (q.size() == 3) break;
            end
        end
        @(posedge clk); #1;
        arvalid = 0;
        tests_run++;
        if (q.size() != 3 || q[0] != 1 || q[1] != 4 || q[2] != 7 || rdata !== model[3]) begin
            tests_failed++;
            $display("FAIL b2b_read: got %0d handshakes %p data=%h expected cycles 1,4,7 data=%h",
                     q.size(), q, rdata, model[3]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alias();
        int lat; logic v; logic [1:0] r; logic [3:0] s1, s2; logic [31:0] d;
        logic [1:0] exp_resp; logic [3:0] exp_stb; logic [31:0] exp_rd;
        do_write(6'h14, 32'h7, 4'hF, lat, v, r, s1, s2);
`ifdef RX_AP_ADDR_CHECK_EN
        exp_resp = 2'b10; exp_stb = 4'b0000; exp_rd = 32'h0;
`else
        exp_resp = 2'b00; exp_stb = 4'b0010; exp_rd = 32'h7;
        model[1] = 32'h7;
`endif
        tests_run++;
        if (r !== exp_resp || s1 !== exp_stb || cfg1 !== model[1] || v !== 1'b1) begin
            tests_failed++;
            $display("FAIL alias_write: got resp=%b stb=%b cfg1=%h expected %b %b %h",
                     r, s1, cfg1, exp_resp, exp_stb, model[1]);
        end
        do_read(6'h14, lat, v, d, r);
        tests_run++;
        if (d !== exp_rd || r !== exp_resp || v !== 1'b1) begin
            tests_failed++;
            $display("FAIL alias_read: got data=%h resp=%b expected %h %b", d, r, exp_rd, exp_resp);
        end
    endtask

    task automatic test_random();
        int lat; logic v; logic [1:0] r; logic [3:0] s1, s2; logic [31:0] d, wd; logic [3:0] ws;
        int idx;
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom; ws = 4'($urandom_range(0, 15));
                do_write(AW'(idx * 4), wd, ws, lat, v, r, s1, s2);
                model[idx] = merge(model[idx], wd, ws);
                tests_run++;
                if (lat !== 1 || r !== 2'b00 || s1 !== (4'b0001 << idx) || s2 !== 4'b0
                    || cfg_of(idx) !== model[idx]) begin
                    tests_failed++;
                    $display("FAIL rand_write%0d: got lat=%0d resp=%b stb=%b cfg=%h expected 1/00/%b/%h",
                             n, lat, r, s1, cfg_of(idx), 4'b0001 << idx, model[idx]);
                end
            end else begin
                do_read(AW'(idx * 4), lat, v, d, r);
                tests_run++;
                if (lat !== 1 || v !== 1'b1 || d !== model[idx] || r !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL rand_read%0d: got lat=%0d rv=%b data=%h resp=%b expected 1/1/%h/00",
                             n, lat, v, d, r, model[idx]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic v; logic [1:0] r; logic [3:0] s1, s2; logic [31:0] d;
        bready = 0; rready = 0;
        do_write(6'h00, 32'hDEADBEEF, 4'hF, lat, v, r, s1, s2);
        do_read(6'h00, lat, v, d, r);
        tests_run++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || cfg0 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL mid_pending: got bv=%b rv=%b cfg0=%h expected 1 1 deadbeef", bvalid, rvalid, cfg0);
        end
        #2;
        aresetn = 0;
        #1;
        for (int k = 0; k < 4; k++) model[k] = '0;
        tests_run++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || {cfg0, cfg1, cfg2, cfg3} !== 128'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_clear: got rv=%b bv=%b cfg=%h_%h_%h_%h expected 0 0 all zero",
                     rvalid, bvalid, cfg0, cfg1, cfg2, cfg3);
        end
        @(posedge clk); #1;
        aresetn = 1; bready = 1; rready = 1;
        @(posedge clk); #1;
        do_read(6'h00, lat, v, d, r);
        tests_run++;
        if (lat !== 1 || v !== 1'b1 || d !== model[0] || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_post_read: got lat=%0d rv=%b data=%h resp=%b expected 1/1/%h/00",
                     lat, v, d, r, model[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_edge();
        test_strobe();
        test_wstrb_zero();
        test_aw_before_w();
        test_back_to_back();
        test_alias();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
